// File: rtl/fetch_pkg.sv
// Shared fetch-path types: address/instruction widths, reset PC and the
// {pc, inst} entry carried through the instruction buffer.
package fetch_pkg;

  localparam int AddrWidth = 32;
  localparam int InstWidth = 32;
  localparam logic [AddrWidth-1:0] ResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    logic [InstWidth-1:0] inst;
  } fetch_entry_t;

  function automatic logic [AddrWidth-1:0] pc_next(input logic [AddrWidth-1:0] pc);
    return pc + AddrWidth'(32'd4);
  endfunction

endpackage

// File: rtl/fetch_buf_ctrl_chk.sv
// Protocol checks for the fetch controller's in-flight bookkeeping.
module fetch_buf_ctrl_chk #(
  parameter int IW      = 3,
  parameter int MAX_OUT = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          rsp_valid,
  input logic [IW-1:0] inflight,
  input logic [IW-1:0] drop_cnt
);

  a_rsp_needs_request: assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (inflight != {IW{1'b0}}));

  a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
    inflight <= IW'(MAX_OUT));

  a_drop_le_inflight: assert property (@(posedge clk) disable iff (reset)
    drop_cnt <= inflight);

endmodule

// File: rtl/fetch_fifo.sv
// Circular instruction buffer with wrap-bit pointers; registered storage,
// no read bypass, contents are not reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH) + 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  entry_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign count   = CW'(wptr - rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr <= {PW{1'b0}};
      rptr <= {PW{1'b0}};
    end else begin
      if (do_push) wptr <= wptr + PW'(1'b1);
      if (do_pop)  rptr <= rptr + PW'(1'b1);
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr[PW-2:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_buf_ctrl.sv
// Fetch request generator with credit-reserved instruction buffer and
// redirect handling that discards responses of superseded requests.
module fetch_buf_ctrl
  import fetch_pkg::*;
#(
  parameter int               ADDR     = AddrWidth,
  parameter int               INST     = InstWidth,
  parameter int               DEPTH    = 8,
  parameter int               MAX_OUT  = 4,
  parameter logic [ADDR-1:0]  RESET_PC = ResetPc
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  output logic [ADDR-1:0] req_pc,
  input  logic            req_ready,
  input  logic            rsp_valid,
  input  logic [INST-1:0] rsp_inst,
  input  logic            redirect,
  input  logic [ADDR-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [INST-1:0] dec_inst,
  output logic [ADDR-1:0] dec_pc,
  input  logic            dec_stall
);

  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR-1:0] fetch_pc;
  logic [ADDR-1:0] rsp_pc;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   drop_cnt;

  logic [ADDR-1:0] fetch_nxt;
  logic [ADDR-1:0] rsp_pc_nxt;
  logic [IW-1:0]   inflight_nxt;
  logic [IW-1:0]   drop_nxt;
  logic            room;
  logic            accept;
  logic            rsp_seen;
  logic            keep_rsp;
  logic            drop_rsp;
  logic            push;
  logic            pop;

  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  fetch_entry_t    wdata;
  fetch_entry_t    rdata;

  assign req_pc    = fetch_pc;
  assign dec_valid = !reset && !empty;
  assign dec_pc    = rdata.pc;
  assign dec_inst  = rdata.inst;
  assign wdata     = '{pc: rsp_pc, inst: rsp_inst};

  always_comb begin
    room         = 1'b0;
    req_valid    = 1'b0;
    accept       = 1'b0;
    rsp_seen     = 1'b0;
    keep_rsp     = 1'b0;
    drop_rsp     = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    inflight_nxt = inflight;
    drop_nxt     = drop_cnt;
    fetch_nxt    = fetch_pc;
    rsp_pc_nxt   = rsp_pc;

    // Requests reserve a buffer slot at issue so a response always has room.
    room      = (32'(inflight) + 32'(count)) < 32'(DEPTH);
    req_valid = !reset && !redirect && (inflight < IW'(MAX_OUT)) && room;
    accept    = req_valid && req_ready;
    rsp_seen  = rsp_valid && (inflight != {IW{1'b0}});
    drop_rsp  = rsp_seen && (drop_cnt != {IW{1'b0}});
    keep_rsp  = rsp_seen && (drop_cnt == {IW{1'b0}});
    push      = keep_rsp && !redirect && !full;
    pop       = dec_valid && !dec_stall && !redirect;

    if (accept && !rsp_seen) begin
      inflight_nxt = inflight + IW'(1'b1);
    end else if (!accept && rsp_seen) begin
      inflight_nxt = inflight - IW'(1'b1);
    end else begin
      inflight_nxt = inflight;
    end

    // On redirect every request still outstanding becomes stale.
    if (redirect) begin
      fetch_nxt  = redirect_pc;
      rsp_pc_nxt = redirect_pc;
      drop_nxt   = inflight_nxt;
    end else begin
      fetch_nxt  = accept ? pc_next(fetch_pc) : fetch_pc;
      rsp_pc_nxt = push ? pc_next(rsp_pc) : rsp_pc;
      drop_nxt   = drop_rsp ? (drop_cnt - IW'(1'b1)) : drop_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= {IW{1'b0}};
      drop_cnt <= {IW{1'b0}};
    end else begin
      fetch_pc <= fetch_nxt;
      rsp_pc   <= rsp_pc_nxt;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  fetch_buf_ctrl_chk #(
    .IW      (IW),
    .MAX_OUT (MAX_OUT)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .rsp_valid (rsp_valid),
    .inflight  (inflight),
    .drop_cnt  (drop_cnt)
  );

endmodule

// File: tb/tb_fetch_buf_ctrl.sv
// Bench for fetch_buf_ctrl: hand-derived vector table, directed corner
// sequences and a random run against a queue-based reference model.
module tb_fetch_buf_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_stall;

  always #5 clk = ~clk;

  fetch_buf_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_inst    (rsp_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_stall   (dec_stall)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding I-cache requests and buffered instructions.
  typedef struct { logic [31:0] pc; bit stale; int t; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  req_t        oq[$];
  ent_t        bq[$];
  logic [31:0] m_fetch;
  int          cyc = 0;
  int          dut_acc = 0;

  typedef struct {
    bit rdy; bit rsp; bit stall; bit redir; logic [31:0] rpc;
    bit rv; logic [31:0] rq_pc; bit dv; logic [31:0] dpc;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(bit rdy, bit rsp, bit stall, bit redir, logic [31:0] rpc,
                              bit rv, logic [31:0] rq_pc, bit dv, logic [31:0] dpc);
    vec_t v;
    v = '{rdy, rsp, stall, redir, rpc, rv, rq_pc, dv, dpc};
    return v;
  endfunction

  function automatic logic [31:0] mem(logic [31:0] pc);
    return (pc * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit rsp_ok();
    return (oq.size() > 0) && ((cyc - oq[0].t) >= 2);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    oq.delete();
    bq.delete();
    m_fetch = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_inst = 32'h0;
    dec_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_req_valid", 32'(req_valid), 32'h0);
    chk("reset_dec_valid", 32'(dec_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, compare against model (and table row if any), advance model.
  task automatic step(bit rdy, bit rsp, bit stall, bit redir, logic [31:0] rpc, int row);
    bit   exp_rv, exp_dv, acc, popd, got_rsp;
    req_t r;
    req_ready   = rdy;
    got_rsp     = rsp && (oq.size() > 0);
    rsp_valid   = got_rsp;
    rsp_inst    = got_rsp ? mem(oq[0].pc) : 32'h0;
    dec_stall   = stall;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    if (row >= 0) begin
      chk("tbl_req_valid", 32'(req_valid), 32'(tbl[row].rv));
      if (tbl[row].rv) chk("tbl_req_pc", req_pc, tbl[row].rq_pc);
      chk("tbl_dec_valid", 32'(dec_valid), 32'(tbl[row].dv));
      if (tbl[row].dv) begin
        chk("tbl_dec_pc", dec_pc, tbl[row].dpc);
        chk("tbl_dec_inst", dec_inst, mem(tbl[row].dpc));
      end
    end
    exp_rv = !redir && (oq.size() < 4) && ((oq.size() + bq.size()) < 8);
    exp_dv = (bq.size() != 0);
    chk("req_valid", 32'(req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_pc", req_pc, m_fetch);
    chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      chk("dec_pc", dec_pc, bq[0].pc);
      chk("dec_inst", dec_inst, bq[0].inst);
    end
    if (req_valid && req_ready) dut_acc++;

    acc  = exp_rv && rdy;
    popd = exp_dv && !stall;
    r    = '{32'h0, 1'b1, 0};
    if (got_rsp) r = oq.pop_front();
    if (redir) begin
      bq.delete();
      foreach (oq[i]) oq[i].stale = 1'b1;
      m_fetch = rpc;
    end else begin
      if (popd) void'(bq.pop_front());
      if (got_rsp && !r.stale) bq.push_back('{r.pc, mem(r.pc)});
      if (acc) begin
        oq.push_back('{m_fetch, 1'b0, cyc});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 24; i++) step(1'b0, rsp_ok(), 1'b0, 1'b0, 32'h0, -1);
  endtask

  initial begin
    // rdy rsp stall redir rpc | req_valid req_pc dec_valid dec_pc
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0,   1, 32'hC,   0, 32'h0);
    tbl[4]  = mk(1, 1, 0, 0, 32'h0,   0, 32'h10,  0, 32'h0);
    tbl[5]  = mk(1, 1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h0);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,   1, 32'h14,  1, 32'h4);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0,   1, 32'h14,  0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 1, 32'h100, 0, 32'h0,   0, 32'h0);
    tbl[9]  = mk(1, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[10] = mk(0, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    tbl[11] = mk(0, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    tbl[12] = mk(0, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100);

    do_reset();
    for (int r = 0; r < 14; r++)
      step(tbl[r].rdy, tbl[r].rsp, tbl[r].stall, tbl[r].redir, tbl[r].rpc, r);

    // Redirect coinciding with a response and a pop while two requests are out.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, -1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, -1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, -1);
    #1 chk("redir_rsp_pop_empty", 32'(dec_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, -1);
    #1 chk("redir_rsp_pop_first_pc", dec_pc, 32'h200);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    drain();

    // Decode stalled forever: exactly DEPTH requests, then no more.
    dut_acc = 0;
    for (int i = 0; i < 30; i++) step(1'b1, rsp_ok(), 1'b1, 1'b0, 32'h0, -1);
    chk("stall_accepts", 32'(dut_acc), 32'd8);
    #1 chk("stall_req_valid_low", 32'(req_valid), 32'h0);
    drain();

    // Fetch PC wraps at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    #1 chk("pc_wrap", req_pc, 32'h0);
    drain();

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset();
      step(1'($urandom % 2), rsp_ok() && (($urandom % 4) != 0), ($urandom % 10) < 3,
           ($urandom % 25) == 0, $urandom & 32'hFFFF_FFFC, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
